// File: rtl/cpu_exec_pipe.sv
// Execute/writeback stage: single-cycle ALU, shift and logic units plus an
// iterative shift-add multiplier, behind a valid/ready input handshake.
module cpu_exec_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [1:0]       f0,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             cin,
  input  logic             bin,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             cout,
  output logic             zero,
  output logic             err,
  output logic [WIDTH-1:0] out_wb,
  output logic             wb_valid
);

  typedef enum logic {IDLE, MUL_RUN} state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_LOG = 4'd3;
  localparam logic [3:0] OP_SHF = 4'd4;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d, wb_q;
  logic               ov_q, ov_d, wbv_q;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic               hi_q, hi_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic [WIDTH:0]     add_w, sub_w;
  logic [2*WIDTH-1:0] rot_w;
  logic [WIDTH-1:0]   sra_w;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_err;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mstep_sum;
  logic [2*WIDTH-1:0] mstep, mfull;
  logic [WIDTH-1:0]   mres;

  assign sh    = inp2[SHW-1:0];
  assign add_w = {1'b0, inp1} + {1'b0, inp2} + {{WIDTH{1'b0}}, cin};
  assign sub_w = {1'b0, inp1} - {1'b0, inp2} - {{WIDTH{1'b0}}, bin};
  assign rot_w = {inp1, inp1} << sh;
  assign sra_w = $signed(inp1) >>> sh;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    unique case (1'b1)
      (opcode == OP_ADD): {alu_c, alu_res} = add_w;
      (opcode == OP_SUB): begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
      end
      (opcode == OP_LOG): begin
        unique case (f0)
          2'b00:   alu_res = inp1 & inp2;
          2'b01:   alu_res = inp1 | inp2;
          2'b10:   alu_res = inp1 ^ inp2;
          default: alu_res = ~inp1;
        endcase
      end
      (opcode == OP_SHF): begin
        unique case (f0)
          2'b00:   alu_res = inp1 << sh;
          2'b01:   alu_res = inp1 >> sh;
          2'b10:   alu_res = sra_w;
          default: alu_res = rot_w[2*WIDTH-1:WIDTH];
        endcase
      end
      (opcode == OP_MUL): begin
      end
      default: alu_err = 1'b1;
    endcase
  end

  // Signed modes run the unsigned engine on magnitudes and fix the sign at the end
  assign a_neg = f0[1] & inp1[WIDTH-1];
  assign b_neg = f0[1] & inp2[WIDTH-1];
  assign a_mag = a_neg ? -inp1 : inp1;
  assign b_mag = b_neg ? -inp2 : inp2;

  assign mstep_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, prod_q[0] ? mcand_q : {WIDTH{1'b0}}};
  assign mstep = {mstep_sum, prod_q[WIDTH-1:1]};
  assign mfull = neg_q ? -mstep : mstep;
  assign mres  = hi_q ? mfull[2*WIDTH-1:WIDTH] : mfull[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    cout_d  = cout_q;
    zero_d  = zero_q;
    err_d   = err_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (opcode == OP_MUL) begin
            mcand_d = a_mag;
            prod_d  = {{WIDTH{1'b0}}, b_mag};
            neg_d   = a_neg ^ b_neg;
            hi_d    = f0[0];
            cnt_d   = '0;
            state_d = MUL_RUN;
          end else begin
            out_d  = alu_res;
            cout_d = alu_c;
            zero_d = (alu_res == '0);
            err_d  = alu_err;
            ov_d   = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        prod_d = mstep;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          out_d   = mres;
          cout_d  = 1'b0;
          zero_d  = (mres == '0);
          err_d   = 1'b0;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      ov_q    <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      wb_q    <= '0;
      wbv_q   <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      wb_q    <= out_q;
      wbv_q   <= ov_q;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out       = out_q;
  assign out_valid = ov_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign out_wb    = wb_q;
  assign wb_valid  = wbv_q;

endmodule

// File: tb/tb_cpu_exec_pipe.sv
// Scoreboard bench for cpu_exec_pipe at WIDTH=16: a behavioural model fills
// an expectation queue at accept, a negedge monitor pops it on out_valid.
module tb_cpu_exec_pipe;

  typedef struct packed {
    logic [15:0] out;
    logic        c;
    logic        z;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [1:0]  f0 = '0;
  logic [15:0] inp1 = '0;
  logic [15:0] inp2 = '0;
  logic        cin = 1'b0;
  logic        bin = 1'b0;
  logic [15:0] out, out_wb;
  logic        out_valid, cout, zero, err, wb_valid;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  exp_t sbq[$];
  logic [15:0] wbq[$];
  int vcyc[$];

  cpu_exec_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .f0(f0),
    .inp1(inp1), .inp2(inp2),
    .cin(cin), .bin(bin),
    .out(out), .out_valid(out_valid),
    .cout(cout), .zero(zero), .err(err),
    .out_wb(out_wb), .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] op, input logic [1:0] f,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic bi);
    exp_t e;
    logic [16:0] w;
    logic [31:0] p;
    longint sa, sb;
    int s;
    e = '0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b} + 17'(c);
        e.out = w[15:0];
        e.c = w[16];
      end
      4'd1: begin
        if (f[1]) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          p = 32'(sa * sb);
        end else begin
          p = {16'h0, a} * {16'h0, b};
        end
        e.out = f[0] ? p[31:16] : p[15:0];
      end
      4'd2: begin
        e.out = a - b - 16'(bi);
        e.c = (int'(a) < int'(b) + int'(bi));
      end
      4'd3: begin
        case (f)
          2'd0: e.out = a & b;
          2'd1: e.out = a | b;
          2'd2: e.out = a ^ b;
          default: e.out = ~a;
        endcase
      end
      4'd4: begin
        s = int'(b[3:0]);
        case (f)
          2'd0: e.out = a << s;
          2'd1: e.out = a >> s;
          2'd2: e.out = 16'($signed(a) >>> s);
          default: begin
            e.out = a;
            repeat (s) e.out = {e.out[14:0], e.out[15]};
          end
        endcase
      end
      default: e.e = 1'b1;
    endcase
    e.z = (e.out == 16'h0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [15:0] w;
    if (rst_n && out_valid) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: out=%h, required no result", out);
      end else begin
        e = sbq.pop_front();
        if ({out, cout, zero, err} !== e) begin
          n_fail++;
          $display("FAIL result: out=%h c=%b z=%b e=%b, required out=%h c=%b z=%b e=%b",
                   out, cout, zero, err, e.out, e.c, e.z, e.e);
        end
        wbq.push_back(e.out);
        vcyc.push_back(cyc);
      end
    end
    if (rst_n && wb_valid) begin
      n_checks++;
      if (wbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wb: out_wb=%h, required no writeback", out_wb);
      end else begin
        w = wbq.pop_front();
        if (out_wb !== w) begin
          n_fail++;
          $display("FAIL writeback: out_wb=%h, required %h", out_wb, w);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [1:0] f,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic bi);
    @(negedge clk);
    opcode = op; f0 = f; inp1 = a; inp2 = b; cin = c; bin = bi;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && in_ready !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sbq.push_back(model(op, f, a, b, c, bi));
      #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64 && (sbq.size() != 0 || wbq.size() != 0); i++)
      @(negedge clk);
    n_checks++;
    if (sbq.size() != 0 || wbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d, required 0", sbq.size() + wbq.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out, out_wb, cout, zero, err, out_valid, wb_valid, in_ready} !== {32'h0, 6'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: out=%h wb=%h flags=%b rdy=%b, required zeros rdy=1",
               out, out_wb, {cout, zero, err, out_valid, wb_valid}, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    send(4'd0, 2'd0, 16'd120, 16'd10, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'd130 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL add_latency: ov=%b out=%0d c=%b, required ov=1 out=130 c=0",
               out_valid, out, cout);
    end
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1 || out_wb !== 16'd130 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_wb: wbv=%b wb=%0d ov=%b, required wbv=1 wb=130 ov=0",
               wb_valid, out_wb, out_valid);
    end
    inp1 = 16'h1234; inp2 = 16'h4321; opcode = 4'd3;
    repeat (4) @(negedge clk);
    n_checks++;
    if (out !== 16'd130 || out_wb !== 16'd130) begin
      n_fail++;
      $display("FAIL hold: out=%0d wb=%0d, required 130 130", out, out_wb);
    end
    wait_drain();
  endtask

  task automatic test_mul();
    int busy;
    send(4'd1, 2'd0, 16'd120, 16'd10, 1'b0, 1'b0);
    busy = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) busy++;
    end
    n_checks++;
    if (busy != 0) begin
      n_fail++;
      $display("FAIL mul_ready_low: ready_high_cycles=%0d, required 0", busy);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out !== 16'd1200 || in_ready !== 1'b1 ||
        cyc - acc_cyc != 16) begin
      n_fail++;
      $display("FAIL mul_latency: ov=%b out=%0d rdy=%b lat=%0d, required 1 1200 1 16",
               out_valid, out, in_ready, cyc - acc_cyc);
    end
    wait_drain();
    send(4'd1, 2'd1, 16'd120, 16'd10, 1'b0, 1'b0);
    send(4'd1, 2'd2, 16'hFF88, 16'd10, 1'b0, 1'b0);
    send(4'd1, 2'd3, 16'hFF88, 16'd10, 1'b0, 1'b0);
    send(4'd1, 2'd3, 16'h8000, 16'h8000, 1'b0, 1'b0);
    send(4'd1, 2'd1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    wait_drain();
    n_checks++;
    if (out !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL mul_umax_hi: out=%h, required fffe", out);
    end
  endtask

  task automatic test_back_to_back();
    vcyc.delete();
    send(4'd2, 2'd0, 16'd10, 16'd120, 1'b0, 1'b0);
    send(4'd0, 2'd0, 16'hFFFF, 16'd1, 1'b0, 1'b0);
    send(4'd15, 2'd0, 16'h5555, 16'h1111, 1'b1, 1'b1);
    wait_drain();
    n_checks++;
    if (vcyc.size() != 3 || vcyc[2] - vcyc[0] != 2) begin
      n_fail++;
      $display("FAIL back_to_back: results=%0d, required 3 on consecutive cycles", vcyc.size());
    end
    send(4'd3, 2'd0, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
    send(4'd3, 2'd1, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
    send(4'd3, 2'd2, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
    send(4'd3, 2'd3, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
    send(4'd2, 2'd0, 16'd5, 16'd4, 1'b0, 1'b1);
    wait_drain();
    n_checks++;
    if (err !== 1'b0 || zero !== 1'b1 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b z=%b c=%b, required 0 1 0", err, zero, cout);
    end
  endtask

  task automatic test_shift();
    send(4'd4, 2'd2, 16'h8001, 16'd1, 1'b0, 1'b0);
    send(4'd4, 2'd3, 16'h8001, 16'd1, 1'b0, 1'b0);
    send(4'd4, 2'd1, 16'h8001, 16'd1, 1'b0, 1'b0);
    send(4'd4, 2'd0, 16'h8001, 16'd15, 1'b0, 1'b0);
    send(4'd4, 2'd3, 16'h8001, 16'h00F4, 1'b0, 1'b0);
    send(4'd4, 2'd2, 16'h8001, 16'd0, 1'b0, 1'b0);
    send(4'd4, 2'd1, 16'h8001, 16'd1, 1'b0, 1'b0);
    wait_drain();
    n_checks++;
    if (out !== 16'h4000) begin
      n_fail++;
      $display("FAIL shift_srl: out=%h, required 4000", out);
    end
  endtask

  task automatic test_reset_mid_mul();
    int spurious;
    send(4'd1, 2'd0, 16'd120, 16'd10, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out, out_wb, cout, zero, err, out_valid, wb_valid, in_ready} !== {32'h0, 6'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_mul: out=%h wb=%h flags=%b rdy=%b, required zeros rdy=1",
               out, out_wb, {cout, zero, err, out_valid, wb_valid}, in_ready);
    end
    sbq.delete();
    wbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_mul: spurious=%0d rdy=%b, required 0 1", spurious, in_ready);
    end
    send(4'd0, 2'd0, 16'd5, 16'd7, 1'b1, 1'b0);
    wait_drain();
    n_checks++;
    if (out !== 16'd13) begin
      n_fail++;
      $display("FAIL post_reset_add: out=%0d, required 13", out);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_shift();
    test_reset_mid_mul();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
